// File: rtl/game_pkg.sv
// Shared grid constants, button indices, control FSM encoding and cursor helpers
// for the move input stage.
package game_pkg;

  localparam int GRID_N = 9;
  localparam int SUB_N  = 3;
  localparam int CELLS  = 81;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;
  localparam int BTN_N     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_REL = 2'd2
  } ctrl_state_e;

  function automatic logic [3:0] step_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'(GRID_N - 1) : v - 4'd1;
  endfunction

  function automatic logic [3:0] step_inc(input logic [3:0] v);
    return (v == 4'(GRID_N - 1)) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] board_of(input logic [3:0] row, input logic [3:0] col);
    return (row / 4'(SUB_N)) * 4'(SUB_N) + col / 4'(SUB_N);
  endfunction

  function automatic logic [3:0] tile_of(input logic [3:0] row, input logic [3:0] col);
    return (row % 4'(SUB_N)) * 4'(SUB_N) + col % 4'(SUB_N);
  endfunction

  function automatic logic [6:0] cell_index(input logic [3:0] board, input logic [3:0] tile);
    return 7'(board) * 7'(GRID_N) + 7'(tile);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stable-count debouncer and a
// registered one-cycle press event on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after a full run of differing samples; any agreement restarts the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else if (sync2_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r   <= {CW{1'b0}};
        level_r <= sync2_r;
        rise_r  <= sync2_r;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
        rise_r  <= 1'b0;
      end
    end else begin
      cnt_r  <= {CW{1'b0}};
      rise_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/move_input_ctrl.sv
// Cursor navigation and move request generation for the 9x9 board: debounced
// buttons step a wrapping cursor, select issues a move or rejects an occupied cell.
module move_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic [CELLS-1:0] X_state,
  input  logic [CELLS-1:0] O_state,
  output logic [3:0]       currBoard,
  output logic [3:0]       currTile,
  output logic             move,
  output logic             reject,
  output logic             cursor_blink
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BTN_N-1:0] raw_s;
  logic [BTN_N-1:0] lvl_s;
  logic [BTN_N-1:0] ev_s;
  logic             unused_lvl_s;
  logic [CELLS-1:0] occ_s;

  ctrl_state_e state_r, state_nxt_s;
  logic [3:0]  row_r, col_r, row_nxt_s, col_nxt_s;
  logic [3:0]  board_r, tile_r;
  logic        move_r, reject_r, reject_nxt_s;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r;

  assign raw_s        = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign unused_lvl_s = ^lvl_s[BTN_SEL-1:0];
  assign occ_s        = X_state | O_state;

  for (genvar i = 0; i < BTN_N; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_s[i]),
      .level(lvl_s[i]),
      .rise (ev_s[i])
    );
  end

  // Control FSM next state and cursor stepping; select beats any direction in the same cycle
  always_comb begin
    state_nxt_s  = state_r;
    row_nxt_s    = row_r;
    col_nxt_s    = col_r;
    reject_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ev_s[BTN_SEL]) begin
          if (occ_s[cell_index(board_r, tile_r)]) begin
            reject_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ISSUE;
          end
        end else if (ev_s[BTN_UP]) begin
          row_nxt_s = step_dec(row_r);
        end else if (ev_s[BTN_DOWN]) begin
          row_nxt_s = step_inc(row_r);
        end else if (ev_s[BTN_LEFT]) begin
          col_nxt_s = step_dec(col_r);
        end else if (ev_s[BTN_RIGHT]) begin
          col_nxt_s = step_inc(col_r);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_REL;
      end
      WAIT_REL: begin
        if (!lvl_s[BTN_SEL]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_REL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, cursor and registered outputs; board/tile track the next row/col so they never lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      row_r    <= 4'd4;
      col_r    <= 4'd4;
      board_r  <= 4'd4;
      tile_r   <= 4'd4;
      move_r   <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      row_r    <= row_nxt_s;
      col_r    <= col_nxt_s;
      board_r  <= board_of(row_nxt_s, col_nxt_s);
      tile_r   <= tile_of(row_nxt_s, col_nxt_s);
      move_r   <= (state_nxt_s == ISSUE);
      reject_r <= reject_nxt_s;
    end
  end

  // Free-running blink divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
      blink_r     <= blink_r;
    end
  end

  assign currBoard    = board_r;
  assign currTile     = tile_r;
  assign move         = move_r;
  assign reject       = reject_r;
  assign cursor_blink = blink_r;

endmodule

// File: doc/move_input_ctrl.md
MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles before a raw button level is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, the half-period of the cursor blink in cycles.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_sel  input  1 each  raw, unsynchronised push-buttons, active-high.
REQ-006 SHALL have ports X_state, O_state  input  81 each  per-cell occupancy from the game-state stage; bit index = board*9 + tile.
REQ-007 SHALL have port currBoard  output  4  sub-board index of the cursor, 0..8.
REQ-008 SHALL have port currTile  output  4  tile index of the cursor within that sub-board, 0..8.
REQ-009 SHALL have port move  output  1  one-cycle move request to the game-state stage.
REQ-010 SHALL have port reject  output  1  one-cycle pulse when a select targets an occupied cell.
REQ-011 SHALL have port cursor_blink  output  1  square wave for highlighting the cursor.

Function
REQ-012 SHALL synchronise each raw button through two flip-flops before debouncing.
REQ-013 SHALL debounce each button with its own counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised level, and any bounce restarts the count.
REQ-014 SHALL generate a one-cycle event on each 0->1 transition of a debounced level; releases generate no event.
REQ-015 SHALL hold the cursor as a global row and column on the 9x9 grid, each 0..8.
REQ-016 SHALL drive currBoard = (row/3)*3 + col/3 and currTile = (row%3)*3 + col%3, both registered.
REQ-017 SHALL step the cursor one position per event: up = row-1, down = row+1, left = col-1, right = col+1, with wrap-around 0<->8 in each axis.
REQ-018 SHALL apply at most one direction per cycle when direction events coincide, with priority up > down > left > right; lower-priority events in that cycle are dropped.
REQ-019 SHALL implement a control FSM with states IDLE, ISSUE and WAIT_REL.
REQ-020 In IDLE, a sel event SHALL go to ISSUE if bit (currBoard*9+currTile) of (X_state|O_state) is 0; otherwise it SHALL pulse reject for one cycle and stay in IDLE.
REQ-021 ISSUE SHALL assert move for exactly one cycle with currBoard/currTile stable, then go to WAIT_REL.
REQ-022 WAIT_REL SHALL return to IDLE on the first cycle the debounced sel level is 0.
REQ-023 The cursor SHALL move only in IDLE; direction events in ISSUE or WAIT_REL are discarded.
REQ-024 A sel event SHALL take precedence over a direction event in the same IDLE cycle; the direction event is discarded.
REQ-025 move and reject SHALL never be asserted in the same cycle.
REQ-026 cursor_blink SHALL toggle every BLINK_CYCLES cycles, using a free-running counter that wraps at BLINK_CYCLES-1.

Reset
REQ-027 On rst the block SHALL, asynchronously, set row=4, col=4 (currBoard=4, currTile=4), move=0, reject=0, cursor_blink=0, FSM=IDLE, and clear all debounce and blink counters and debounced levels.
REQ-028 A rst asserted in ISSUE SHALL suppress move on that cycle and all following cycles until a new sel event.
REQ-029 After rst deasserts, a button held through reset SHALL produce an event only after a full DEBOUNCE_CYCLES of the high level.

Structure
REQ-030 Grid constants (GRID_N=9, SUB_N=3, CELLS=81) and the FSM state encoding SHALL live in a shared package, game_pkg.
REQ-031 Debounce plus edge detection SHALL be a sub-module btn_debounce, instantiated five times.

Verification
REQ-032 Reset, then one right event: currBoard=4, currTile=5.
REQ-033 From row=0, col=8, one up event then one right event: row=8, col=0, currBoard=6, currTile=6.
REQ-034 Bench with DEBOUNCE_CYCLES=4: a 3-cycle sel glitch produces no move; a 6-cycle sel press yields move=1 for exactly 1 cycle, and a further 20-cycle hold produces no second move.
REQ-035 With bit 40 set in O_state and the cursor at board 4, tile 4: a sel press gives reject=1 for 1 cycle and move=0.
REQ-036 up and left events in the same cycle from board 4, tile 4: only up is applied, giving board 4, tile 1.
REQ-037 rst asserted in the cycle move would rise: move stays 0, outputs return to their reset values, and cursor_blink=0.
